// File: rtl/fpu_arb_pkg.sv
// Shared constants and FSM state type for the FPU add/sub arbiter slice.
package fpu_arb_pkg;

  localparam int FP_W   = 32;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fpu_arb_state_e;

endpackage

// File: rtl/FPU_32bit.sv
// Combinational IEEE-754 single-precision add/sub, round-to-nearest-even.
// op[0]=0 adds, op[0]=1 subtracts b from a.
module FPU_32bit
  import fpu_arb_pkg::*;
#(
  parameter int NUM_OP = 1
) (
  input  logic [NUM_OP-1:0] op,
  input  logic [FP_W-1:0]   a,
  input  logic [FP_W-1:0]   b,
  output logic [FP_W-1:0]   result
);

  logic        b_sign, swap, eff_sub, sign_l, sign_s, round_up;
  logic [7:0]  exp_l, exp_s, exp_l_eff, exp_s_eff, shift;
  logic [23:0] man_l, man_s;
  logic [26:0] al_ext, as_ext, as_sh, norm;
  logic [27:0] sum;
  logic [9:0]  exp_n;
  logic [24:0] rnd;

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    b_sign    = b[31] ^ op[0];
    swap      = b[30:0] > a[30:0];
    sign_l    = swap ? b_sign : a[31];
    sign_s    = swap ? a[31] : b_sign;
    exp_l     = swap ? b[30:23] : a[30:23];
    exp_s     = swap ? a[30:23] : b[30:23];
    man_l     = {exp_l != 8'd0, swap ? b[22:0] : a[22:0]};
    man_s     = {exp_s != 8'd0, swap ? a[22:0] : b[22:0]};
    eff_sub   = sign_l ^ sign_s;
    exp_l_eff = (exp_l == 8'd0) ? 8'd1 : exp_l;
    exp_s_eff = (exp_s == 8'd0) ? 8'd1 : exp_s;
    shift     = exp_l_eff - exp_s_eff;

    // Three extra bits below the mantissa: guard, round, sticky.
    al_ext = {man_l, 3'b000};
    as_ext = {man_s, 3'b000};
    if (shift >= 8'd27) begin
      as_sh = {26'b0, |as_ext};
    end else begin
      as_sh = (as_ext >> shift) | {26'b0, |(as_ext & ((27'd1 << shift) - 27'd1))};
    end

    sum   = eff_sub ? ({1'b0, al_ext} - {1'b0, as_sh}) : ({1'b0, al_ext} + {1'b0, as_sh});
    exp_n = {2'b00, exp_l_eff};

    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = exp_n + 10'd1;
    end else begin
      norm = sum[26:0];
      for (int i = 0; i < 26; i++) begin
        if (!norm[26] && exp_n > 10'd1) begin
          norm  = norm << 1;
          exp_n = exp_n - 10'd1;
        end
      end
    end
    if (!norm[26]) exp_n = 10'd0;

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[26:3]} + {24'b0, round_up};
    if (rnd[24]) begin
      rnd   = rnd >> 1;
      exp_n = exp_n + 10'd1;
    end else if (exp_n == 10'd0 && rnd[23]) begin
      exp_n = 10'd1;
    end

    if (sum == 28'd0) begin
      result = {eff_sub ? 1'b0 : sign_l, 31'b0};
    end else if (exp_n >= 10'd255) begin
      result = {sign_l, 8'hFF, 23'b0};
    end else begin
      result = {sign_l, exp_n[7:0], rnd[22:0]};
    end

    // Magnitude ordering puts any Inf/NaN operand on the large side.
    if (exp_l == 8'hFF) begin
      if (man_l[22:0] != 23'd0 || (exp_s == 8'hFF && eff_sub)) result = 32'h7FC0_0000;
      else                                                      result = {sign_l, 8'hFF, 23'b0};
    end
  end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Combinational one-hot round-robin grant; search starts at ptr and wraps.
module fpu_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W:0] pos;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
      if (!found && req[pos[ID_W-1:0]]) begin
        grant[pos[ID_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin sharing of one FPU_32bit add/sub among NUM_REQ requesters.
// Define FPU_ARB_STATS_EN to add per-requester 16-bit grant counters (o_grant_cnt).
module fpu_addsub_arbiter
  import fpu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int NUM_OP  = 1,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*NUM_OP-1:0] i_req_op,
  input  logic [NUM_REQ*FP_W-1:0]   i_req_a,
  input  logic [NUM_REQ*FP_W-1:0]   i_req_b,
  output logic                      o_rsp_valid,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [FP_W-1:0]           o_rsp_result,
  input  logic                      i_rsp_ready
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] o_grant_cnt
`endif
);

  fpu_arb_state_e    state_q, state_d;
  logic [ID_W-1:0]   rr_ptr, id_q, win_idx, next_ptr;
  logic [NUM_OP-1:0] op_q, win_op;
  logic [FP_W-1:0]   a_q, b_q, win_a, win_b, fpu_result;
  logic [NUM_REQ-1:0] grant;
  logic              accept;

  fpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (i_req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  FPU_32bit #(.NUM_OP(NUM_OP)) u_fpu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (fpu_result)
  );

  assign o_req_ready = (state_q == IDLE && !i_rst) ? grant : '0;
  assign accept      = (state_q == IDLE) && (|grant);

  always_comb begin
    win_idx = '0;
    win_op  = '0;
    win_a   = '0;
    win_b   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        win_idx = ID_W'(k);
        win_op  = i_req_op[k*NUM_OP +: NUM_OP];
        win_a   = i_req_a[k*FP_W +: FP_W];
        win_b   = i_req_b[k*FP_W +: FP_W];
      end
    end
    next_ptr = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr       <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_id     <= '0;
    end else begin
      if (accept) begin
        op_q   <= win_op;
        a_q    <= win_a;
        b_q    <= win_b;
        id_q   <= win_idx;
        rr_ptr <= next_ptr;
      end
      if (state_q == EXEC) begin
        o_rsp_valid  <= 1'b1;
        o_rsp_result <= fpu_result;
        o_rsp_id     <= id_q;
      end else if (state_q == RESP && i_rsp_ready) begin
        o_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FPU_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_grant_cnt <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant[k]) o_grant_cnt[k*STAT_W +: STAT_W] <= o_grant_cnt[k*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Self-checking bench: fixed vectors, fairness, backpressure, reset, random traffic.
module tb_fpu_addsub_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NUM_OP  = 1;
  localparam int ID_W    = 2;

  logic                      i_clk = 1'b0;
  logic                      i_rst;
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [NUM_REQ*NUM_OP-1:0] i_req_op;
  logic [NUM_REQ*32-1:0]     i_req_a;
  logic [NUM_REQ*32-1:0]     i_req_b;
  logic                      o_rsp_valid;
  logic [ID_W-1:0]           o_rsp_id;
  logic [31:0]               o_rsp_result;
  logic                      i_rsp_ready;
`ifdef FPU_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     o_grant_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  always #5 i_clk = ~i_clk;

  fpu_addsub_arbiter #(.NUM_REQ(NUM_REQ), .NUM_OP(NUM_OP)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_op     (i_req_op),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .i_rsp_ready  (i_rsp_ready)
`ifdef FPU_ARB_STATS_EN
    ,
    .o_grant_cnt  (o_grant_cnt)
`endif
  );

  // Exact single-precision encoding of an integer with magnitude below 2^24.
  function automatic logic [31:0] int_to_fp(input int v);
    logic        s;
    logic [31:0] m;
    int          e;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    e = 31;
    while (m[e] == 1'b0) e--;
    m = m << (23 - e);
    return {s, 8'(127 + e), m[22:0]};
  endfunction

  // First valid requester at or after the model pointer, wrapping; -1 if none.
  function automatic int model_winner(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[(model_ptr + i) % NUM_REQ]) return (model_ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int rand_int();
    return int'($urandom_range(0, 2097152)) - 1048576;
  endfunction

  task automatic reset_dut();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic wait_grant(input int k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_req_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Issues one request from requester k alone; returns at the negedge of the response cycle.
  task automatic run_txn(input int k, input logic op, input logic [31:0] a, input logic [31:0] b,
                         output bit granted, output logic v_exec, output logic v_resp,
                         output logic [31:0] res, output logic [ID_W-1:0] id);
    @(posedge i_clk); #1;
    i_req_valid[k]       = 1'b1;
    i_req_op[k]          = op;
    i_req_a[k*32 +: 32]  = a;
    i_req_b[k*32 +: 32]  = b;
    wait_grant(k, granted);
    @(posedge i_clk); #1;
    i_req_valid[k]       = 1'b0;
    i_req_op[k]          = ~op;
    i_req_a[k*32 +: 32]  = $urandom();
    i_req_b[k*32 +: 32]  = $urandom();
    @(negedge i_clk); v_exec = o_rsp_valid;
    @(negedge i_clk); v_resp = o_rsp_valid; res = o_rsp_result; id = o_rsp_id;
    model_ptr = (k + 1) % NUM_REQ;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req_valid = '1; i_req_op = '0; i_req_a = '0; i_req_b = '0; i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", o_req_ready); end
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_rsp_valid); end
    checks++; if (o_rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", o_rsp_result); end
    checks++; if (o_rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", o_rsp_id); end
    @(posedge i_clk); #1;
    i_req_valid = '0; i_rst = 1'b0; model_ptr = 0;
    @(negedge i_clk);
    checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_req_ready got=%b exp=0000", o_req_ready); end
  endtask

  task automatic test_single_add();
    bit g; logic ve, vr; logic [31:0] r; logic [ID_W-1:0] id;
    run_txn(0, 1'b0, 32'h3F80_0000, 32'h4000_0000, g, ve, vr, r, id);
    checks++; if (!g) begin errors++; $display("FAIL add_grant got=timeout exp=grant"); end
    checks++; if (ve !== 1'b0) begin errors++; $display("FAIL add_latency_early got=%b exp=0", ve); end
    checks++; if (vr !== 1'b1 || r !== 32'h4040_0000 || id !== 2'd0)
      begin errors++; $display("FAIL add_rsp got=v%b %h id%0d exp=v1 40400000 id0", vr, r, id); end
  endtask

  task automatic test_sub();
    bit g; logic ve, vr; logic [31:0] r; logic [ID_W-1:0] id;
    run_txn(2, 1'b1, 32'h4040_0000, 32'h3F80_0000, g, ve, vr, r, id);
    checks++; if (!g || ve !== 1'b0 || vr !== 1'b1 || r !== 32'h4000_0000 || id !== 2'd2)
      begin errors++; $display("FAIL sub_rsp got=g%b v%b%b %h id%0d exp=g1 v01 40000000 id2", g, ve, vr, r, id); end
  endtask

  task automatic test_fairness();
    int ngr = 0, last_grant = -1, last_cycle = 0, w;
    for (int k = 0; k < NUM_REQ; k++) begin
      i_req_op[k] = 1'b0; i_req_a[k*32 +: 32] = int_to_fp(k + 1); i_req_b[k*32 +: 32] = int_to_fp(10);
    end
    i_req_valid = '1; i_rsp_ready = 1'b1;
    reset_dut();
    for (int c = 0; c < 40 && ngr < 6; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        checks++; if (o_rsp_id !== ID_W'(last_grant) || o_rsp_result !== int_to_fp(last_grant + 11))
          begin errors++; $display("FAIL fair_rsp got=id%0d %h exp=id%0d %h", o_rsp_id, o_rsp_result, last_grant, int_to_fp(last_grant + 11)); end
      end
      if (o_req_ready != '0) begin
        w = model_winner(4'b1111);
        checks++; if (!$onehot(o_req_ready) || o_req_ready !== 4'(1 << w))
          begin errors++; $display("FAIL fair_grant got=%b exp=%b", o_req_ready, 4'(1 << w)); end
        if (ngr > 0) begin
          checks++; if (c - last_cycle != 3) begin errors++; $display("FAIL fair_spacing got=%0d exp=3", c - last_cycle); end
        end
        model_ptr = (w + 1) % NUM_REQ; last_grant = w; last_cycle = c; ngr++;
      end
    end
    checks++; if (ngr != 6) begin errors++; $display("FAIL fair_count got=%0d exp=6", ngr); end
    @(posedge i_clk); #1 i_req_valid = '0;
    repeat (3) @(posedge i_clk); #1;
  endtask

  task automatic test_backpressure();
    bit g; logic ve, vr; logic [31:0] r, ra; logic [ID_W-1:0] id;
    int a1 = rand_int(), b1 = rand_int(), a3 = rand_int(), b3 = rand_int();
    i_rsp_ready = 1'b0;
    run_txn(1, 1'b0, int_to_fp(a1), int_to_fp(b1), g, ve, vr, r, id);
    checks++; if (!g || vr !== 1'b1 || r !== int_to_fp(a1 + b1) || id !== 2'd1)
      begin errors++; $display("FAIL bp_rsp got=v%b %h id%0d exp=v1 %h id1", vr, r, id, int_to_fp(a1 + b1)); end
    i_req_valid[3] = 1'b1; i_req_op[3] = 1'b1;
    i_req_a[3*32 +: 32] = int_to_fp(a3); i_req_b[3*32 +: 32] = int_to_fp(b3);
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      checks++; if (o_rsp_valid !== 1'b1 || o_rsp_result !== int_to_fp(a1 + b1) || o_rsp_id !== 2'd1 || o_req_ready !== 4'b0000)
        begin errors++; $display("FAIL bp_hold got=v%b %h id%0d rdy%b exp=v1 %h id1 rdy0000", o_rsp_valid, o_rsp_result, o_rsp_id, o_req_ready, int_to_fp(a1 + b1)); end
    end
    @(posedge i_clk); #1 i_rsp_ready = 1'b1;
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got=%b exp=1", o_rsp_valid); end
    @(negedge i_clk);
    checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 4'b1000)
      begin errors++; $display("FAIL bp_next_grant got=v%b rdy%b exp=v0 rdy1000", o_rsp_valid, o_req_ready); end
    @(posedge i_clk); #1;
    i_req_valid[3] = 1'b0; i_req_a[3*32 +: 32] = $urandom();
    @(negedge i_clk); @(negedge i_clk);
    ra = int_to_fp(a3 - b3);
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_result !== ra || o_rsp_id !== 2'd3)
      begin errors++; $display("FAIL bp_req3_rsp got=v%b %h id%0d exp=v1 %h id3", o_rsp_valid, o_rsp_result, o_rsp_id, ra); end
    model_ptr = 0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    int av[NUM_REQ], bv[NUM_REQ], ov[NUM_REQ];
    logic [NUM_REQ-1:0] mask;
    int w, expv;
    for (int it = 0; it < 40; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < NUM_REQ; k++) begin
        av[k] = rand_int(); bv[k] = ($urandom_range(0, 9) == 0) ? av[k] : rand_int(); ov[k] = int'($urandom_range(0, 1));
        i_req_op[k] = ov[k][0]; i_req_a[k*32 +: 32] = int_to_fp(av[k]); i_req_b[k*32 +: 32] = int_to_fp(bv[k]);
      end
      i_req_valid = mask; i_rsp_ready = 1'b0;
      w = model_winner(mask);
      @(negedge i_clk);
      checks++; if (o_req_ready !== 4'(1 << w)) begin errors++; $display("FAIL rand_grant it=%0d got=%b exp=%b", it, o_req_ready, 4'(1 << w)); end
      @(posedge i_clk); #1;
      i_req_valid = '0; i_req_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_ptr = (w + 1) % NUM_REQ;
      @(negedge i_clk); @(negedge i_clk);
      expv = (ov[w] != 0) ? av[w] - bv[w] : av[w] + bv[w];
      checks++; if (o_rsp_valid !== 1'b1 || o_rsp_id !== ID_W'(w) || o_rsp_result !== int_to_fp(expv))
        begin errors++; $display("FAIL rand_rsp it=%0d got=v%b id%0d %h exp=v1 id%0d %h", it, o_rsp_valid, o_rsp_id, o_rsp_result, w, int_to_fp(expv)); end
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
      #1 i_rsp_ready = 1'b1;
      @(posedge i_clk); #1 i_rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_exec();
    bit g; int seen = 0;
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid[2] = 1'b1; i_req_a[2*32 +: 32] = int_to_fp(5); i_req_b[2*32 +: 32] = int_to_fp(7);
    wait_grant(2, g);
    @(posedge i_clk); #1;
    i_req_valid = '0; i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (!g || o_req_ready !== 4'b0000) begin errors++; $display("FAIL rst_exec_ready got=g%b rdy%b exp=g1 rdy0000", g, o_req_ready); end
    @(posedge i_clk); #1 i_rst = 1'b0; model_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_exec_no_rsp got=%0d exp=0", seen); end
    @(posedge i_clk); #1 i_req_valid = '1;
    @(negedge i_clk);
    checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL rst_exec_ptr got=%b exp=0001", o_req_ready); end
    @(posedge i_clk); #1 i_req_valid = '0; model_ptr = 1;
    repeat (3) @(posedge i_clk); #1;
  endtask

`ifdef FPU_ARB_STATS_EN
  task automatic test_stats();
    bit g; logic ve, vr; logic [31:0] r; logic [ID_W-1:0] id;
    i_rsp_ready = 1'b1;
    reset_dut();
    @(negedge i_clk);
    checks++; if (o_grant_cnt !== '0) begin errors++; $display("FAIL stats_reset got=%h exp=0", o_grant_cnt); end
    for (int n = 0; n < 3; n++) run_txn(1, 1'b0, int_to_fp(n), int_to_fp(1), g, ve, vr, r, id);
    run_txn(3, 1'b0, int_to_fp(2), int_to_fp(2), g, ve, vr, r, id);
    checks++; if (o_grant_cnt !== {16'd1, 16'd0, 16'd3, 16'd0})
      begin errors++; $display("FAIL stats_counts got=%h exp=%h", o_grant_cnt, {16'd1, 16'd0, 16'd3, 16'd0}); end
    @(posedge i_clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_sub();
    test_fairness();
    test_backpressure();
    test_random();
    test_reset_mid_exec();
`ifdef FPU_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
